// File: rtl/fetch_if.sv
// fetch_if: stall/redirect control, imem and IF/ID bundle for fetch_stage.
// master: control inputs and imem read data in, PC/IF-ID/counters out.
// slave: the fetch stage side.
interface fetch_if #(parameter int CNT_W = 32);
  logic             pcWrite;
  logic             ifWrite;
  logic             branchTaken;
  logic [31:0]      branchTarget;
  logic [31:0]      imemData;
  logic [31:0]      imemAddr;
  logic [31:0]      ifIdInstr;
  logic [31:0]      ifIdPcPlus4;
  logic             ifIdValid;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;
  modport master(output pcWrite, ifWrite, branchTaken, branchTarget, imemData,
                 input imemAddr, ifIdInstr, ifIdPcPlus4, ifIdValid, stallCount, flushCount);
  modport slave(input pcWrite, ifWrite, branchTaken, branchTarget, imemData,
                output imemAddr, ifIdInstr, ifIdPcPlus4, ifIdValid, stallCount, flushCount);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage - PC, imem address, IF/ID register, stall/flush counters.
// Ports: clk, resetN (async active-low), bus (fetch_if.slave) carrying
// pcWrite/ifWrite/branchTaken/branchTarget/imemData in and
// imemAddr/ifIdInstr/ifIdPcPlus4/ifIdValid/stallCount/flushCount out.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input logic   clk,
  input logic   resetN,
  fetch_if.slave bus
);
  logic [31:0]      pc, instr, pc_plus4_q;
  logic             valid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [31:0]      pc_plus4;
  logic             flush;
  assign pc_plus4 = pc + 32'd4;
  // A redirect seen while the stall unit holds the PC is dropped; the branch
  // is still in ID and will be re-evaluated when the stall releases.
  assign flush = bus.branchTaken & bus.pcWrite;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid      <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bus.pcWrite) pc <= flush ? {bus.branchTarget[31:2], 2'b00} : pc_plus4;
      if (bus.ifWrite) begin
        instr      <= flush ? NOP_INSTR : bus.imemData;
        pc_plus4_q <= flush ? 32'd0 : pc_plus4;
        valid      <= ~flush;
      end
      if (!bus.pcWrite) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && bus.ifWrite) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign bus.imemAddr    = pc;
  assign bus.ifIdInstr   = instr;
  assign bus.ifIdPcPlus4 = pc_plus4_q;
  assign bus.ifIdValid   = valid;
  assign bus.stallCount  = stall_cnt;
  assign bus.flushCount  = flush_cnt;
endmodule
